// File: rtl/data_mem_responder.sv
// Data-memory responder: captures a core request, waits WAIT_CYCLES, then
// reads or writes a word-addressed RAM and holds response until request falls.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   request               core holds high for one transaction
//   wren                  1 = write, 0 = read (sampled with request in IDLE)
//   address, writedata    word address and write data (sampled in IDLE)
//   readdata              read result, valid while response = 1
//   response              transaction done, held until request is seen low
module data_mem_responder #(
    parameter int WIDTH       = 32,
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             request,
    input  logic             wren,
    input  logic [WIDTH-1:0] address,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    output logic             response
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_t;

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [7:0] LAST_CNT =
        8'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    state_t state;
    state_t state_nxt;

    logic [7:0]           cnt;
    logic                 wren_q;
    logic [WIDTH-1:0]     addr_q;
    logic [WIDTH-1:0]     wdata_q;
    logic                 cap_en;
    logic                 cnt_en;
    logic                 acc_en;
    logic                 rsp_clr;
    logic                 in_range;
    logic [ADDR_BITS-1:0] idx;

    logic [WIDTH-1:0] mem [DEPTH];

    assign idx      = addr_q[ADDR_BITS-1:0];
    // Any set bit above the RAM index makes the access out of range.
    assign in_range = (addr_q[WIDTH-1:ADDR_BITS] == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (request) begin
                    state_nxt = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                if (cnt == LAST_CNT) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (!request) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        cap_en  = 1'b0;
        cnt_en  = 1'b0;
        acc_en  = 1'b0;
        rsp_clr = 1'b0;
        unique case (state)
            IDLE:   cap_en  = request;
            WAIT:   cnt_en  = 1'b1;
            ACCESS: acc_en  = 1'b1;
            RESP:   rsp_clr = !request;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wren_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt      <= '0;
            readdata <= '0;
            response <= 1'b0;
        end else begin
            if (cap_en) begin
                wren_q  <= wren;
                addr_q  <= address;
                wdata_q <= writedata;
                cnt     <= '0;
            end
            if (cnt_en) begin
                cnt <= cnt + 8'd1;
            end
            if (acc_en) begin
                response <= 1'b1;
                // Writes and out-of-range reads both report zero.
                readdata <= (wren_q || !in_range) ? '0 : mem[idx];
            end
            if (rsp_clr) begin
                response <= 1'b0;
            end
        end
    end

    // RAM contents survive reset; only an in-range write in ACCESS stores.
    always_ff @(posedge clk) begin
        if (acc_en && wren_q && in_range) begin
            mem[idx] <= wdata_q;
        end
    end

endmodule
